// File: rtl/ahb_bus_arbiter_if.sv
// Arbiter-side bundle of the shared AHB bus: requests, muxed transfer control, grant and owner indices.
// The arbiter connects through 'slave'; the requester/bus side drives through 'master'.
interface ahb_bus_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int MW          = $clog2(NUM_MASTERS)
);
  logic [NUM_MASTERS-1:0] hbusreq;
  logic [NUM_MASTERS-1:0] hlock;
  logic [1:0]             htrans;
  logic [2:0]             hburst;
  logic                   hready;
  logic [NUM_MASTERS-1:0] hgrant;
  logic [MW-1:0]          hmaster;
  logic [MW-1:0]          hmaster_dp;
  logic                   hmastlock;

  modport master (
    output hbusreq, hlock, htrans, hburst, hready,
    input  hgrant, hmaster, hmaster_dp, hmastlock
  );

  modport slave (
    input  hbusreq, hlock, htrans, hburst, hready,
    output hgrant, hmaster, hmaster_dp, hmastlock
  );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB arbiter: registered one-hot grant, address/data-phase owner pipeline, burst/lock hold-off.
// Grant reaches HMASTER one ready-cycle later and HMASTER_DP one after that; HREADY=0 freezes all state.
module ahb_bus_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int MW          = $clog2(NUM_MASTERS)
) (
  input logic              HCLK,
  input logic              HRESETn,
  ahb_bus_arbiter_if.slave bus
);

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;
  localparam logic [2:0] B_INCR   = 3'd1;
  localparam logic [NUM_MASTERS-1:0] GNT_M0 = NUM_MASTERS'(1);

  typedef enum logic [1:0] {PARK, GRANTED, BURST, LOCK} state_t;

  state_t                 state, state_nxt;
  logic [NUM_MASTERS-1:0] hgrant;
  logic [MW-1:0]          gnt_idx, hmaster, hmaster_dp, rr_ptr;
  logic [MW-1:0]          scan_idx, cand;
  logic [MW:0]            cand_sum;
  logic                   hmastlock;
  logic [4:0]             beats_left, beats_nxt, burst_len;
  logic                   fixed_len, last_beat, owner_req, owner_lock;
  logic                   rearb_cond, rearb, any_req;

  // Length 0 stands for the unbounded INCR burst.
  always_comb begin
    burst_len = 5'd0;
    case (bus.hburst)
      3'd0:       burst_len = 5'd1;
      3'd2, 3'd3: burst_len = 5'd4;
      3'd4, 3'd5: burst_len = 5'd8;
      3'd6, 3'd7: burst_len = 5'd16;
      default:    burst_len = 5'd0;
    endcase
  end

  assign fixed_len = (bus.hburst != B_INCR);

  always_comb begin
    beats_nxt = beats_left;
    case (bus.htrans)
      T_NONSEQ: beats_nxt = fixed_len ? (burst_len - 5'd1) : 5'd0;
      T_SEQ:    if (beats_left != 5'd0) beats_nxt = beats_left - 5'd1;
      T_IDLE:   beats_nxt = 5'd0;
      default:  beats_nxt = beats_left;
    endcase
  end

  assign last_beat  = ((bus.htrans == T_NONSEQ) && (burst_len == 5'd1)) ||
                      ((bus.htrans == T_SEQ) && fixed_len && (beats_left == 5'd1));
  assign owner_req  = bus.hbusreq[hmaster];
  assign owner_lock = bus.hlock[hmaster];
  assign rearb_cond = (bus.htrans == T_IDLE) || last_beat ||
                      ((bus.hburst == B_INCR) && !owner_req);

  // Scan rr_ptr+1 .. rr_ptr+N so the last winner is considered last.
  always_comb begin
    any_req  = 1'b0;
    scan_idx = '0;
    cand_sum = '0;
    cand     = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      cand_sum = {1'b0, rr_ptr} + (MW+1)'(i);
      if (cand_sum >= (MW+1)'(NUM_MASTERS))
        cand_sum = cand_sum - (MW+1)'(NUM_MASTERS);
      cand = cand_sum[MW-1:0];
      if (!any_req && bus.hbusreq[cand]) begin
        any_req  = 1'b1;
        scan_idx = cand;
      end
    end
  end

  // A burst is "in flight" whenever the beat counter will be non-zero after this edge.
  always_comb begin
    rearb     = 1'b0;
    state_nxt = state;
    case (state)
      PARK:    rearb = 1'b1;
      GRANTED: begin
        if (owner_lock)               state_nxt = LOCK;
        else if (beats_nxt != 5'd0)   state_nxt = BURST;
        else if (rearb_cond)          rearb = 1'b1;
      end
      BURST: begin
        if (beats_nxt == 5'd0) begin
          if (owner_lock) state_nxt = LOCK;
          else            rearb = 1'b1;
        end
      end
      LOCK: begin
        if (!owner_lock) begin
          if (beats_nxt != 5'd0) state_nxt = BURST;
          else begin
            state_nxt = GRANTED;
            rearb     = rearb_cond;
          end
        end
      end
      default: state_nxt = PARK;
    endcase
    if (rearb) state_nxt = any_req ? GRANTED : PARK;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state      <= PARK;
      hgrant     <= GNT_M0;
      gnt_idx    <= '0;
      hmaster    <= '0;
      hmaster_dp <= '0;
      hmastlock  <= 1'b0;
      rr_ptr     <= '0;
      beats_left <= 5'd0;
    end else if (bus.hready) begin
      hmaster_dp <= hmaster;
      hmaster    <= gnt_idx;
      beats_left <= beats_nxt;
      state      <= state_nxt;
      hmastlock  <= (state_nxt == LOCK);
      if (rearb) begin
        if (any_req) begin
          hgrant  <= GNT_M0 << scan_idx;
          gnt_idx <= scan_idx;
          rr_ptr  <= scan_idx;
        end else begin
          hgrant  <= GNT_M0;
          gnt_idx <= '0;
        end
      end
    end
  end

  assign bus.hgrant     = hgrant;
  assign bus.hmaster    = hmaster;
  assign bus.hmaster_dp = hmaster_dp;
  assign bus.hmastlock  = hmastlock;

endmodule
